// File: rtl/uart_rx_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_rx_param                                                   |
// | Desc     : Oversampling UART receiver, majority-vote sampling, valid/ready |
// |            output, overrun detection and RTS. Define UART_RX_FIFO_EN to    |
// |            replace the holding register with a FWFT FIFO of FIFO_DEPTH.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module uart_rx_param #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 rts,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);

  localparam int c_TICKS_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int c_TICKS     = (c_TICKS_RAW < 1) ? 1 : c_TICKS_RAW;
  localparam int c_DIV_W     = (c_TICKS > 1) ? $clog2(c_TICKS) : 1;
  localparam int c_SC_W      = $clog2(OVERSAMPLE);
  localparam int c_BC_W      = $clog2(DATA_BITS);

  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_TICKS - 1);
  localparam logic [c_SC_W-1:0]  c_SC_S0    = c_SC_W'(OVERSAMPLE/2 - 1);
  localparam logic [c_SC_W-1:0]  c_SC_S1    = c_SC_W'(OVERSAMPLE/2);
  localparam logic [c_SC_W-1:0]  c_SC_DEC   = c_SC_W'(OVERSAMPLE/2 + 1);
  localparam logic [c_SC_W-1:0]  c_SC_END   = c_SC_W'(OVERSAMPLE - 1);
  localparam logic [c_BC_W-1:0]  c_BC_LAST  = c_BC_W'(DATA_BITS - 1);
  localparam logic               c_STOP_LAST = (STOP_BITS == 2);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_START  = 3'd1;
  localparam logic [2:0] c_ST_DATA   = 3'd2;
  localparam logic [2:0] c_ST_PARITY = 3'd3;
  localparam logic [2:0] c_ST_STOP   = 3'd4;

  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 || c_TICKS_RAW < 1 ||
      FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_rx_param: illegal parameter combination");
  end

  logic                 r_sync1;
  logic                 r_rxs;
  logic [c_DIV_W-1:0]   r_div;
  logic [c_SC_W-1:0]    r_sc;
  logic                 r_s0;
  logic                 r_s1;
  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [c_BC_W-1:0]    r_bit_cnt;
  logic                 r_stop_cnt;
  logic                 r_par_bad;
  logic                 r_stop_bad;

  logic w_start;
  logic w_tick;
  logic w_dec;
  logic w_end;
  logic w_maj;
  logic w_busy;
  logic w_shift_en;
  logic w_par_chk;
  logic w_stop_chk;
  logic w_done;
  logic w_par_calc;
  logic w_par_bad_now;
  logic w_stop_bad_final;
  logic w_good;
  logic w_can_push;
  logic w_push;
  logic w_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rxs   <= r_sync1;
    end
  end

  // Divider and sample counter restart on the start edge so sample points
  // land relative to the falling edge of the start bit.
  assign w_start = (r_state == c_ST_IDLE) && !r_rxs;
  assign w_tick  = (r_div == c_DIV_LAST);
  assign w_dec   = w_tick && (r_sc == c_SC_DEC);
  assign w_end   = w_tick && (r_sc == c_SC_END);
  assign w_maj   = (r_s0 & r_s1) | (r_s0 & r_rxs) | (r_s1 & r_rxs);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
      r_sc  <= '0;
      r_s0  <= 1'b1;
      r_s1  <= 1'b1;
    end else begin
      if (w_start || w_tick) r_div <= '0;
      else                   r_div <= r_div + 1'b1;

      if (w_start)     r_sc <= '0;
      else if (w_tick) r_sc <= (r_sc == c_SC_END) ? '0 : r_sc + 1'b1;

      if (w_tick && r_sc == c_SC_S0) r_s0 <= r_rxs;
      if (w_tick && r_sc == c_SC_S1) r_s1 <= r_rxs;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:   if (!r_rxs) w_state_nxt = c_ST_START;
      c_ST_START: begin
        if (w_dec && w_maj) w_state_nxt = c_ST_IDLE;
        else if (w_end)     w_state_nxt = c_ST_DATA;
      end
      c_ST_DATA: begin
        if (w_end && r_bit_cnt == c_BC_LAST)
          w_state_nxt = (PARITY != 0) ? c_ST_PARITY : c_ST_STOP;
      end
      c_ST_PARITY: if (w_end) w_state_nxt = c_ST_STOP;
      // Leave at the final stop decision, not bit end, to catch back-to-back starts.
      c_ST_STOP:   if (w_dec && r_stop_cnt == c_STOP_LAST) w_state_nxt = c_ST_IDLE;
      default:     w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy     = 1'b1;
    w_shift_en = 1'b0;
    w_par_chk  = 1'b0;
    w_stop_chk = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      c_ST_IDLE:   w_busy     = 1'b0;
      c_ST_DATA:   w_shift_en = w_dec;
      c_ST_PARITY: w_par_chk  = w_dec;
      c_ST_STOP: begin
        w_stop_chk = w_dec;
        w_done     = w_dec && (r_stop_cnt == c_STOP_LAST);
      end
      default: ;
    endcase
  end

  assign busy = w_busy;

  assign w_par_calc       = ^{r_shift, w_maj};
  assign w_par_bad_now    = (PARITY == 1) ? ~w_par_calc : w_par_calc;
  assign w_stop_bad_final = r_stop_bad | ~w_maj;
  assign w_good           = w_done && !w_stop_bad_final && !r_par_bad;
  assign w_push           = w_good && w_can_push;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_par_bad  <= 1'b0;
      r_stop_bad <= 1'b0;
    end else begin
      if (w_start) begin
        r_bit_cnt  <= '0;
        r_stop_cnt <= 1'b0;
        r_par_bad  <= 1'b0;
        r_stop_bad <= 1'b0;
      end
      if (w_shift_en) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
      if (r_state == c_ST_DATA && w_end) r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_par_chk) r_par_bad <= w_par_bad_now;
      if (w_stop_chk) begin
        r_stop_cnt <= r_stop_cnt + 1'b1;
        r_stop_bad <= w_stop_bad_final;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= w_done && w_stop_bad_final;
      parity_err  <= w_done && r_par_bad;
      overrun_err <= w_good && !w_can_push;
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam logic [c_AW:0] c_DEPTH   = (c_AW+1)'(FIFO_DEPTH);
  localparam logic [c_AW:0] c_RTS_LVL = (c_AW+1)'(FIFO_DEPTH - 2);

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]      r_wptr;
  logic [c_AW-1:0]      r_rptr;
  logic [c_AW:0]        r_count;
  logic [c_AW:0]        w_count_nxt;
  logic                 r_rts;

  assign m_valid    = (r_count != '0);
  assign w_pop      = m_valid && m_ready;
  assign w_can_push = (r_count != c_DEPTH) || w_pop;
  assign m_data     = m_valid ? r_mem[r_rptr] : '0;
  assign rts        = r_rts;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + 1'b1;
    else if (!w_push && w_pop) w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= r_shift;
  end

  // Threshold two below full leaves room for frames already on the wire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_rts   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
      r_rts   <= (w_count_nxt >= c_RTS_LVL);
    end
  end
`else
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_rts;
  logic                 w_valid_nxt;

  assign w_pop       = r_valid && m_ready;
  assign w_can_push  = !r_valid || m_ready;
  assign w_valid_nxt = w_push || (r_valid && !w_pop);
  assign m_data      = r_data;
  assign m_valid     = r_valid;
  assign rts         = r_rts;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_rts   <= 1'b0;
    end else begin
      if (w_push) r_data <= r_shift;
      r_valid <= w_valid_nxt;
      r_rts   <= w_valid_nxt;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_rx_param                                                |
// | Desc     : Scoreboard bench for uart_rx_param, 8E2 at 128 clk per bit.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_uart_rx_param;

  localparam int CLK_FREQ   = 12000000;
  localparam int BAUD_RATE  = 93750;
  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int PARITY     = 2;
  localparam int STOP_BITS  = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int BIT_CLKS   = CLK_FREQ / BAUD_RATE;
`ifdef UART_RX_FIFO_EN
  localparam int CAP     = FIFO_DEPTH;
  localparam int RTS_LVL = FIFO_DEPTH - 2;
`else
  localparam int CAP     = 1;
  localparam int RTS_LVL = 1;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 rx;
  logic [DATA_BITS-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 rts;
  logic                 busy;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun_err;

  int checks = 0;
  int errors = 0;
  int ready_mode = 1;  // 0 random, 1 hold off, 2 always ready
  logic [7:0] exp_words[$];
  logic [2:0] exp_errs[$];

  uart_rx_param #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .OVERSAMPLE(OVERSAMPLE),
    .DATA_BITS(DATA_BITS), .PARITY(PARITY), .STOP_BITS(STOP_BITS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .rts(rts), .busy(busy), .frame_err(frame_err),
    .parity_err(parity_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT reports a word or an error.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err || parity_err || overrun_err) begin
        if (exp_errs.size() == 0) check("unexpected_err", {frame_err, parity_err, overrun_err}, 0);
        else check("err_code", {frame_err, parity_err, overrun_err}, exp_errs.pop_front());
      end
      if (m_valid && m_ready) begin
        if (exp_words.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", m_data);
        end else check("word", m_data, exp_words.pop_front());
      end
    end
  end

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'($urandom_range(0, 1));
        1:       m_ready = 1'b0;
        default: m_ready = 1'b1;
      endcase
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input logic [1:0] stops);
    logic p;
    p = ^d;
    if (bad_par) p = ~p;
    drive_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
    drive_bit(p);
    for (int i = 0; i < STOP_BITS; i++) drive_bit(stops[i]);
    rx = 1'b1;
  endtask

  // Reference model: what the line protocol says this frame should produce,
  // given how many unconsumed words storage already holds.
  task automatic issue_frame(input logic [7:0] d, input bit bad_par, input logic [1:0] stops,
                             input int held);
    bit fe;
    fe = (stops[0] == 1'b0) || (STOP_BITS == 2 && stops[1] == 1'b0);
    if (fe || bad_par)    exp_errs.push_back({fe, bad_par, 1'b0});
    else if (held >= CAP) exp_errs.push_back(3'b001);
    else                  exp_words.push_back(d);
    send_frame(d, bad_par, stops);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] d;
    int kind;
    reset = 1'b1;
    rx    = 1'b1;
    idle(5);
    check("reset_outputs", {m_data, m_valid, rts, busy, frame_err, parity_err, overrun_err}, 0);
    reset = 1'b0;
    idle(20);

    ready_mode = 2;
    issue_frame(8'hA5, 1'b0, 2'b11, 0);
    idle(BIT_CLKS);
    check("rts_after_consumed", rts, 0);
    issue_frame(8'h03, 1'b1, 2'b11, 0);
    idle(2 * BIT_CLKS);
    issue_frame(8'h03, 1'b0, 2'b11, 0);
    idle(10);
    issue_frame(8'h7E, 1'b0, 2'b01, 0);
    idle(2 * BIT_CLKS);
    issue_frame(8'h81, 1'b1, 2'b10, 0);
    idle(2 * BIT_CLKS);

    // Glitch shorter than half a bit must be rejected silently.
    check("busy_idle", busy, 0);
    rx = 1'b0;
    idle(3);
    check("busy_rise", busy, 1);
    idle(37);
    rx = 1'b1;
    idle(200);
    check("busy_after_glitch", busy, 0);
    issue_frame(8'h5A, 1'b0, 2'b11, 0);
    idle(10);

    ready_mode = 0;
    for (int n = 0; n < 24; n++) begin
      d    = 8'($urandom);
      kind = int'($urandom_range(0, 9));
      case (kind)
        0, 1:    issue_frame(d, 1'b1, 2'b11, 0);
        2:       issue_frame(d, 1'b0, 2'($urandom_range(0, 2)), 0);
        3:       issue_frame(d, 1'b1, 2'b10, 0);
        default: issue_frame(d, 1'b0, 2'b11, 0);
      endcase
      if (kind <= 3) idle(2 * BIT_CLKS);
      else           idle(int'($urandom_range(0, 20)));
    end
    ready_mode = 2;
    idle(50);

    ready_mode = 1;
    idle(5);
    check("rts_empty", rts, 0);
    for (int k = 0; k <= CAP; k++) begin
      issue_frame(8'((k + 1) * 8'h11), 1'b0, 2'b11, k);
      idle(20);
      check("rts_level", rts, ((k + 1 >= CAP ? CAP : k + 1) >= RTS_LVL) ? 1 : 0);
      check("valid_held", m_valid, 1);
    end
    check("head_stable", m_data, 8'h11);
    ready_mode = 2;
    idle(20);
    check("valid_drained", m_valid, 0);
    check("rts_drained", rts, 0);

    // Reset in the middle of the data bits of 0xFF.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    #3;
    reset = 1'b1;
    #1;
    check("mid_reset_outputs", {m_data, m_valid, rts, busy, frame_err, parity_err, overrun_err}, 0);
    rx = 1'b1;
    idle(5);
    check("held_reset_outputs", {m_data, m_valid, rts, busy, frame_err, parity_err, overrun_err}, 0);
    reset = 1'b0;
    idle(20);
    issue_frame(8'h42, 1'b0, 2'b11, 0);
    idle(BIT_CLKS);

    for (int i = 0; i < 5000 && (exp_words.size() != 0 || exp_errs.size() != 0); i++)
      @(posedge clk);
    check("words_outstanding", exp_words.size(), 0);
    check("errs_outstanding", exp_errs.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
